cdnsusbhs_cdc_hs_tx: RTL and testbench

//  Transmit (source) end of a 4-phase req/ack clock-domain-crossing handshake carrying a DATA_W word.

---
 rtl/cdnsusbhs_cdc_hs_pkg.sv | 12 +
 rtl/cdnsusbhs_cdc_ack_sync.sv | 27 ++
 rtl/cdnsusbhs_cdc_hs_tx.sv | 127 ++++++++++++
 tb/tb_cdnsusbhs_cdc_hs_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdnsusbhs_cdc_hs_pkg.sv
// Shared definitions for the USB HS clock-domain-crossing handshake blocks.
//   ST_IDLE / ST_REQ / ST_RELEASE : transmit FSM state encodings
//   SYNC_STAGES                   : depth of the ack synchronizer
package cdnsusbhs_cdc_hs_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cdnsusbhs_cdc_ack_sync.sv
// Multi-flop level synchronizer for the far-domain ack.
//   clk      : destination clock
//   srst     : synchronous active-high reset, clears every stage to 0
//   async_in : level from the far clock domain
//   sync_out : level after SYNC_STAGES flops
module cdnsusbhs_cdc_ack_sync
  import cdnsusbhs_cdc_hs_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/cdnsusbhs_cdc_hs_tx.sv
// Source end of a 4-phase req/ack clock-domain-crossing handshake.
// A word accepted on tx_valid/tx_ready is held on cdc_data while cdc_req is
// raised; the far-end ack comes back through a 2-flop synchronizer.
//   txclk, txrst           : clock and synchronous active-high reset
//   tx_valid/tx_ready      : word offer / accept
//   tx_data                : word to send
//   tx_done                : 1-cycle pulse on successful handshake completion
//   tx_timeout             : sticky request-timeout flag, cleared by tx_timeout_clr
//   busy                   : FSM not idle
//   cdc_req, cdc_data      : registered request level and held word to far domain
//   cdc_ack_async          : far-domain ack level (asynchronous)
module cdnsusbhs_cdc_hs_tx
  import cdnsusbhs_cdc_hs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic              txclk,
  input  logic              txrst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_done,
  output logic              tx_timeout,
  input  logic              tx_timeout_clr,
  output logic              busy,
  output logic              cdc_req,
  output logic [DATA_W-1:0] cdc_data,
  input  logic              cdc_ack_async
);

  localparam bit                   TIMEOUT_EN   = (TIMEOUT != 0);
  // Only meaningful when TIMEOUT_EN; wraps to all-ones otherwise.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state_reg;
  logic                 req_reg;
  logic [DATA_W-1:0]    data_reg;
  logic                 done_reg;
  logic                 timeout_reg;
  logic                 abort_reg;
  logic [TIMEOUT_W-1:0] cnt_reg;
  logic                 ack_s;
  logic                 accept;
  logic                 timeout_hit;

  cdnsusbhs_cdc_ack_sync u_ack_sync (
    .clk      (txclk),
    .srst     (txrst),
    .async_in (cdc_ack_async),
    .sync_out (ack_s)
  );

  // A stale ack still high from an abandoned request blocks new requests.
  assign tx_ready = (state_reg == ST_IDLE) & ~ack_s;
  assign accept   = tx_valid & tx_ready;

  // Ack has priority over the timeout when both occur in the same cycle.
  assign timeout_hit = TIMEOUT_EN && (state_reg == ST_REQ) && !ack_s &&
                       (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge txclk) begin
    if (txrst) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            data_reg  <= tx_data;
            req_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            req_reg   <= 1'b0;
            state_reg <= ST_RELEASE;
          end else if (timeout_hit) begin
            req_reg   <= 1'b0;
            abort_reg <= 1'b1;
            state_reg <= ST_RELEASE;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Wait for the far end to drop ack so the 4-phase cycle closes.
          if (!ack_s) begin
            done_reg  <= ~abort_reg;
            abort_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge txclk) begin
    if (txrst) begin
      timeout_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_reg <= 1'b1;
    end else if (tx_timeout_clr) begin
      timeout_reg <= 1'b0;
    end
  end

  assign tx_done    = done_reg;
  assign tx_timeout = timeout_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign cdc_req    = req_reg;
  assign cdc_data   = data_reg;

endmodule

// File: tb/tb_cdnsusbhs_cdc_hs_tx.sv
// Testbench for cdnsusbhs_cdc_hs_tx: three instances (TIMEOUT = 0, 16, 8)
// share a clock and reset; each has its own stimulus and far-end ack model.
module tb_cdnsusbhs_cdc_hs_tx;

  localparam int N  = 3;
  localparam int DW = 32;

  logic          clk;
  logic          txrst;
  logic          tx_valid       [N];
  logic [DW-1:0] tx_data        [N];
  logic          tx_timeout_clr [N];
  logic          ack            [N];
  logic          tx_ready       [N];
  logic          tx_done        [N];
  logic          tx_timeout     [N];
  logic          busy           [N];
  logic          cdc_req        [N];
  logic [DW-1:0] cdc_data       [N];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdnsusbhs_cdc_hs_tx #(.DATA_W(DW), .TIMEOUT_W(16), .TIMEOUT(0)) u_dut0 (
    .txclk(clk), .txrst(txrst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_data(tx_data[0]), .tx_done(tx_done[0]), .tx_timeout(tx_timeout[0]),
    .tx_timeout_clr(tx_timeout_clr[0]), .busy(busy[0]), .cdc_req(cdc_req[0]),
    .cdc_data(cdc_data[0]), .cdc_ack_async(ack[0]));

  cdnsusbhs_cdc_hs_tx #(.DATA_W(DW), .TIMEOUT_W(16), .TIMEOUT(16)) u_dut1 (
    .txclk(clk), .txrst(txrst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_data(tx_data[1]), .tx_done(tx_done[1]), .tx_timeout(tx_timeout[1]),
    .tx_timeout_clr(tx_timeout_clr[1]), .busy(busy[1]), .cdc_req(cdc_req[1]),
    .cdc_data(cdc_data[1]), .cdc_ack_async(ack[1]));

  cdnsusbhs_cdc_hs_tx #(.DATA_W(DW), .TIMEOUT_W(16), .TIMEOUT(8)) u_dut2 (
    .txclk(clk), .txrst(txrst), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .tx_data(tx_data[2]), .tx_done(tx_done[2]), .tx_timeout(tx_timeout[2]),
    .tx_timeout_clr(tx_timeout_clr[2]), .busy(busy[2]), .cdc_req(cdc_req[2]),
    .cdc_data(cdc_data[2]), .cdc_ack_async(ack[2]));

  function automatic int to_of(input int k);
    case (k)
      1:       return 16;
      2:       return 8;
      default: return 0;
    endcase
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    txrst = 1'b1;
    for (int k = 0; k < N; k++) begin
      tx_valid[k]       = 1'b0;
      tx_timeout_clr[k] = 1'b0;
    end
    step();
    step();
    txrst = 1'b0;
  endtask

  // One full transfer on instance k. Far-end model: ack rises once req has
  // been seen high for d1 samples (d1=0: never acks) and falls d2 samples
  // after req is seen low. Expected timing from the handshake rules: the ack
  // reaches the FSM 2 cycles later, ack beats timeout, so req stays high
  // d1+2 cycles unless that exceeds a nonzero TIMEOUT.
  task automatic run_transfer(input int k, input logic [DW-1:0] d,
                              input int d1, input int d2, input int clr_at);
    int   hi, lo, done_cnt, busy_len, data_bad, ready_bad, w, to;
    int   exp_hi, exp_len, exp_done;
    logic prior_to, exp_to;
    bit   timed_out;
    hi = 0; lo = 0; done_cnt = 0; busy_len = -1; data_bad = 0; ready_bad = 0;
    to = to_of(k);
    w = 0;
    while (!tx_ready[k] && w < 50) begin
      step();
      w++;
    end
    n_tests++;
    if (tx_ready[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait k=%0d tx_ready=%b required 1 within 50 cycles", k, tx_ready[k]);
      return;
    end
    prior_to = tx_timeout[k];
    tx_valid[k] = 1'b1;
    tx_data[k]  = d;
    step();
    tx_valid[k] = 1'b0;
    tx_data[k]  = $urandom();

    timed_out = (to != 0) && (d1 == 0 || d1 + 2 > to);
    exp_hi    = timed_out ? to : d1 + 2;
    exp_len   = timed_out ? to + 1 : exp_hi + d2 + 2;
    exp_done  = timed_out ? 0 : 1;
    exp_to    = timed_out ? 1'b1 : ((clr_at > 0) ? 1'b0 : prior_to);

    for (int i = 0; i < 400; i++) begin
      if (cdc_data[k] !== d) data_bad++;
      if (busy[k] && tx_ready[k]) ready_bad++;
      if (tx_done[k] === 1'b1) done_cnt++;
      if (busy[k] !== 1'b1) begin
        busy_len = i;
        break;
      end
      if (cdc_req[k]) hi++;
      else lo++;
      if (d1 != 0 && cdc_req[k] && hi == d1) ack[k] = 1'b1;
      if (ack[k] && !cdc_req[k] && lo == d2) ack[k] = 1'b0;
      tx_timeout_clr[k] = (clr_at > 0 && i == clr_at - 1);
      step();
    end
    tx_timeout_clr[k] = 1'b0;
    step();
    if (tx_done[k] === 1'b1) done_cnt++;

    n_tests++;
    if (hi != exp_hi) begin
      n_fail++;
      $display("FAIL req_high k=%0d d1=%0d cycles=%0d required %0d", k, d1, hi, exp_hi);
    end
    n_tests++;
    if (busy_len != exp_len) begin
      n_fail++;
      $display("FAIL busy_len k=%0d d1=%0d d2=%0d cycles=%0d required %0d", k, d1, d2, busy_len, exp_len);
    end
    n_tests++;
    if (done_cnt != exp_done) begin
      n_fail++;
      $display("FAIL done_pulses k=%0d count=%0d required %0d", k, done_cnt, exp_done);
    end
    n_tests++;
    if (data_bad != 0) begin
      n_fail++;
      $display("FAIL data_hold k=%0d bad_samples=%0d required 0 (word %h)", k, data_bad, d);
    end
    n_tests++;
    if (ready_bad != 0) begin
      n_fail++;
      $display("FAIL ready_while_busy k=%0d samples=%0d required 0", k, ready_bad);
    end
    n_tests++;
    if (tx_timeout[k] !== exp_to) begin
      n_fail++;
      $display("FAIL timeout_flag k=%0d tx_timeout=%b required %b", k, tx_timeout[k], exp_to);
    end
    $display("[TB] xfer k=%0d data=%h d1=%0d d2=%0d req_cycles=%0d busy=%0d done=%0d timeout=%b",
             k, d, d1, d2, hi, busy_len, done_cnt, tx_timeout[k]);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (tx_ready[k] !== 1'b1 || cdc_req[k] !== 1'b0 || cdc_data[k] !== '0 ||
          busy[k] !== 1'b0 || tx_done[k] !== 1'b0 || tx_timeout[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state k=%0d ready=%b req=%b data=%h busy=%b done=%b to=%b required 1 0 0 0 0 0",
                 k, tx_ready[k], cdc_req[k], cdc_data[k], busy[k], tx_done[k], tx_timeout[k]);
      end
    end
    $display("[TB] reset checked on %0d instances", N);
  endtask

  task automatic test_basic();
    run_transfer(1, 32'hA5A5_0001, 3, 3, 0);
  endtask

  task automatic test_timeout();
    run_transfer(1, 32'h0BAD_0016, 0, 0, 0);
    tx_timeout_clr[1] = 1'b1;
    step();
    tx_timeout_clr[1] = 1'b0;
    n_tests++;
    if (tx_timeout[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear tx_timeout=%b required 0", tx_timeout[1]);
    end
    $display("[TB] timeout clear tx_timeout=%b", tx_timeout[1]);
  endtask

  task automatic test_timeout_disabled();
    apply_reset();
    tx_valid[0] = 1'b1;
    tx_data[0]  = 32'h0000_D15A;
    step();
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 40; i++) step();
    n_tests++;
    if (cdc_req[0] !== 1'b1 || tx_timeout[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout_when_0 req=%b to=%b busy=%b required 1 0 1",
               cdc_req[0], tx_timeout[0], busy[0]);
    end
    $display("[TB] TIMEOUT=0 after 40 cycles req=%b timeout=%b", cdc_req[0], tx_timeout[0]);
    apply_reset();
  endtask

  task automatic test_stale_ack();
    ack[1] = 1'b1;
    apply_reset();
    step();
    step();
    n_tests++;
    if (tx_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_ack_ready tx_ready=%b required 0", tx_ready[1]);
    end
    tx_valid[1] = 1'b1;
    tx_data[1]  = 32'h5A5A_0004;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (cdc_req[1] !== 1'b0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_ack_accept req=%b busy=%b required 0 0", cdc_req[1], busy[1]);
    end
    ack[1] = 1'b0;
    step();
    n_tests++;
    if (tx_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_fall_plus1 tx_ready=%b required 0", tx_ready[1]);
    end
    step();
    n_tests++;
    if (tx_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_fall_plus2 tx_ready=%b required 1", tx_ready[1]);
    end
    step();
    tx_valid[1] = 1'b0;
    n_tests++;
    if (cdc_req[1] !== 1'b1 || cdc_data[1] !== 32'h5A5A_0004) begin
      n_fail++;
      $display("FAIL late_accept req=%b data=%h required 1 5a5a0004", cdc_req[1], cdc_data[1]);
    end
    $display("[TB] stale ack: accepted after ack fall req=%b data=%h", cdc_req[1], cdc_data[1]);
    apply_reset();
  endtask

  task automatic test_reset_mid_req();
    tx_valid[1] = 1'b1;
    tx_data[1]  = 32'hCAFE_0005;
    step();
    tx_valid[1] = 1'b0;
    step();
    step();
    n_tests++;
    if (cdc_req[1] !== 1'b1 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req req=%b busy=%b required 1 1", cdc_req[1], busy[1]);
    end
    txrst  = 1'b1;
    ack[1] = 1'b1;
    step();
    txrst = 1'b0;
    n_tests++;
    if (cdc_req[1] !== 1'b0 || busy[1] !== 1'b0 || tx_done[1] !== 1'b0 || cdc_data[1] !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_req req=%b busy=%b done=%b data=%h required 0 0 0 0",
               cdc_req[1], busy[1], tx_done[1], cdc_data[1]);
    end
    step();
    step();
    step();
    n_tests++;
    if (tx_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL abandoned_ack_ready tx_ready=%b required 0", tx_ready[1]);
    end
    $display("[TB] reset in REQ: req=%b busy=%b", cdc_req[1], busy[1]);
    ack[1] = 1'b0;
    run_transfer(1, 32'hCAFE_0006, 3, 3, 0);
  endtask

  task automatic test_ack_vs_timeout();
    apply_reset();
    run_transfer(2, 32'h0000_0008, 6, 2, 0);
    run_transfer(2, 32'h0000_0009, 0, 0, 8);
  endtask

  task automatic test_back_to_back();
    int hi, lo;
    apply_reset();
    hi = 0;
    lo = 0;
    tx_valid[0] = 1'b1;
    tx_data[0]  = 32'h1111_AAAA;
    step();
    tx_data[0]  = 32'h2222_BBBB;
    // ack after 2 req samples -> req high 4 cycles, idle 2+2 cycles later.
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cdc_data[0] !== 32'h1111_AAAA || tx_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold i=%0d data=%h ready=%b required 1111aaaa 0", i, cdc_data[0], tx_ready[0]);
      end
      if (cdc_req[0]) hi++;
      else lo++;
      if (cdc_req[0] && hi == 2) ack[0] = 1'b1;
      if (ack[0] && !cdc_req[0] && lo == 2) ack[0] = 1'b0;
      step();
    end
    n_tests++;
    if (tx_ready[0] !== 1'b1 || tx_done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle ready=%b done=%b required 1 1", tx_ready[0], tx_done[0]);
    end
    step();
    tx_valid[0] = 1'b0;
    n_tests++;
    if (cdc_req[0] !== 1'b1 || cdc_data[0] !== 32'h2222_BBBB) begin
      n_fail++;
      $display("FAIL b2b_second req=%b data=%h required 1 2222bbbb", cdc_req[0], cdc_data[0]);
    end
    $display("[TB] back-to-back second word req=%b data=%h", cdc_req[0], cdc_data[0]);
    apply_reset();
  endtask

  task automatic test_random();
    int d1, d2;
    for (int n = 0; n < 10; n++) begin
      d1 = $urandom_range(1, 20);
      d2 = $urandom_range(1, 6);
      run_transfer(0, $urandom(), d1, d2, 0);
    end
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        d1 = 0;
        d2 = 0;
      end else begin
        d1 = $urandom_range(1, 14);
        d2 = $urandom_range(1, 6);
      end
      run_transfer(1, $urandom(), d1, d2, 0);
    end
  endtask

  initial begin
    txrst = 1'b1;
    for (int k = 0; k < N; k++) begin
      tx_valid[k]       = 1'b0;
      tx_data[k]        = '0;
      tx_timeout_clr[k] = 1'b0;
      ack[k]            = 1'b0;
    end
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_disabled();
    test_stale_ack();
    test_reset_mid_req();
    test_ack_vs_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
